data_mem_arbiter: RTL and testbench

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

---
 rtl/data_mem_arb_pkg.sv | 17 +
 rtl/data_mem_arbiter_rr_arb2.sv | 27 ++
 rtl/data_mem_arbiter.sv | 123 ++++++++++++
 tb/tb_data_mem_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_arb_pkg.sv
// Shared types and default sizing for the two-port data-memory arbiter.
package data_mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    // 0 = CPU port, 1 = DMA port
    typedef logic port_id_t;

    localparam int DEF_DEPTH = 100;
    localparam int DEF_AW    = 32;
    localparam int DEF_DW    = 32;

endpackage

// File: rtl/data_mem_arbiter_rr_arb2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the port
// that was not granted last.
module rr_arb2
    import data_mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant,
    output logic       gid
);

    port_id_t pick;

    always_comb begin
        pick = 1'b0;
        unique case (req)
            2'b01:   pick = 1'b0;
            2'b10:   pick = 1'b1;
            2'b11:   pick = ~last;
            default: pick = 1'b0;
        endcase
    end

    assign gid   = pick;
    assign grant = (req == 2'b00) ? 2'b00 : (pick ? 2'b10 : 2'b01);

endmodule

// File: rtl/data_mem_arbiter.sv
// Arbitrates CPU (port 0) and DMA (port 1) accesses onto one data memory;
// each access runs IDLE -> ACCESS -> DONE and out-of-range addresses ack with err.
module data_mem_arbiter
    import data_mem_arb_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = DEF_AW,
    parameter int DW    = DEF_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          ack0,
    output logic          ack1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          err,
    output logic          mem_read,
    output logic          mem_write,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    state_t        state, state_nxt;
    logic [1:0]    grant;
    port_id_t      gid;
    port_id_t      last;
    logic          start;

    logic          we_p0;
    logic [AW-1:0] addr_p0;
    logic [DW-1:0] wdata_p0;
    port_id_t      gid_p0;
    logic          oor_p0;

    rr_arb2 u_rr_arb2 (
        .req   ({req1, req0}),
        .last  (last),
        .grant (grant),
        .gid   (gid)
    );

    assign start  = (state == IDLE) && (grant != 2'b00);
    assign oor_p0 = (addr_p0 >= AW'(DEPTH));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        ack0      = 1'b0;
        ack1      = 1'b0;
        err       = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_nxt = ACCESS;
            end
            ACCESS: begin
                state_nxt = DONE;
                mem_read  = !we_p0 && !oor_p0;
                mem_write =  we_p0 && !oor_p0;
            end
            DONE: begin
                state_nxt = IDLE;
                ack0      = (gid_p0 == 1'b0);
                ack1      = (gid_p0 == 1'b1);
                err       = oor_p0;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // p0: winner's request latched on IDLE -> ACCESS; last-grant pointer
    // starts at port 1 so port 0 takes the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_p0    <= 1'b0;
            addr_p0  <= '0;
            wdata_p0 <= '0;
            gid_p0   <= 1'b0;
            last     <= 1'b1;
        end else if (start) begin
            we_p0    <= gid ? we1    : we0;
            addr_p0  <= gid ? addr1  : addr0;
            wdata_p0 <= gid ? wdata1 : wdata0;
            gid_p0   <= gid;
            last     <= gid;
        end
    end

    assign mem_addr  = addr_p0;
    assign mem_wdata = wdata_p0;

    // p1: read data captured on ACCESS -> DONE; an out-of-range access
    // clears the winner's register instead.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata0 <= '0;
            rdata1 <= '0;
        end else if (state == ACCESS) begin
            if (oor_p0) begin
                if (gid_p0) rdata1 <= '0;
                else        rdata0 <= '0;
            end else if (!we_p0) begin
                if (gid_p0) rdata1 <= mem_rdata;
                else        rdata0 <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a behavioural memory and an
// in-order scoreboard of expected completions.
module tb_data_mem_arbiter;

    localparam int DEPTH = 100;
    localparam int AW    = 32;
    localparam int DW    = 32;

    typedef struct {
        logic          port;
        logic          chk_rdata;
        logic [DW-1:0] rdata;
        logic          err;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic          ack0, ack1, err, mem_read, mem_write;
    logic [DW-1:0] rdata0, rdata1, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;

    exp_t          sb[$];
    exp_t          mon_e;
    int            checks = 0;
    int            errors = 0;

    logic [DW-1:0] wmem    [0:127];
    bit            written [0:127];

    always #5 clk = ~clk;

    data_mem_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (req0),
        .req1      (req1),
        .we0       (we0),
        .we1       (we1),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .ack0      (ack0),
        .ack1      (ack1),
        .rdata0    (rdata0),
        .rdata1    (rdata1),
        .err       (err),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    function automatic logic [DW-1:0] pat(input int i);
        return 32'hA000_0000 + 32'(i);
    endfunction

    // Memory: combinational read, write committed on the falling edge.
    always_comb begin
        mem_rdata = 32'hDEAD_BEEF;
        if (mem_addr < 32'(DEPTH))
            mem_rdata = written[mem_addr[6:0]] ? wmem[mem_addr[6:0]] : pat(int'(mem_addr[6:0]));
    end

    always @(negedge clk) begin
        if (mem_write && mem_addr < 32'(DEPTH)) begin
            wmem[mem_addr[6:0]]    <= mem_wdata;
            written[mem_addr[6:0]] <= 1'b1;
        end
    end

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: every ack is matched in order against the queue.
    always @(negedge clk) begin
        if (ack0 || ack1) begin
            check1("ack_exclusive", ack0 && ack1, 1'b0);
            if (sb.size() == 0) begin
                check("unexpected_ack", {30'd0, ack1, ack0}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check1("ack_port", ack1, mon_e.port);
                check1("ack_err", err, mon_e.err);
                if (mon_e.chk_rdata)
                    check("ack_rdata", mon_e.port ? rdata1 : rdata0, mon_e.rdata);
            end
        end else begin
            check1("err_without_ack", err, 1'b0);
        end
    end

    // Single access from IDLE; called at a falling edge, returns at a falling edge in IDLE.
    task automatic serve(input logic port, input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wd, input logic [DW-1:0] exp_rd);
        exp_t e;
        logic inr;
        inr         = (addr < 32'(DEPTH));
        e.port      = port;
        e.err       = !inr;
        e.chk_rdata = !we || !inr;
        e.rdata     = inr ? exp_rd : '0;
        sb.push_back(e);
        if (port) begin
            req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wd;
        end else begin
            req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wd;
        end
        @(posedge clk);
        @(negedge clk);
        check1("acc_mem_write", mem_write, we && inr);
        check1("acc_mem_read", mem_read, !we && inr);
        check("acc_mem_addr", mem_addr, addr);
        if (we) check("acc_mem_wdata", mem_wdata, wd);
        check1("acc_no_ack", ack0 | ack1, 1'b0);
        req0 = 1'b0; req1 = 1'b0;
        addr0 = $urandom; addr1 = $urandom; wdata0 = $urandom; wdata1 = $urandom;
        we0 = ~we; we1 = ~we;
        @(negedge clk);
        check1("done_ack", port ? ack1 : ack0, 1'b1);
        check1("done_no_strobe", mem_read | mem_write, 1'b0);
        @(negedge clk);
        check1("idle_quiet", ack0 | ack1 | mem_read | mem_write | err, 1'b0);
    endtask

    initial begin
        exp_t e;
        int   n;
        int   nd;

        // Reset state
        @(negedge clk);
        check1("rst_ack0", ack0, 1'b0);
        check1("rst_ack1", ack1, 1'b0);
        check1("rst_err", err, 1'b0);
        check1("rst_strobes", mem_read | mem_write, 1'b0);
        check("rst_rdata0", rdata0, '0);
        check("rst_rdata1", rdata1, '0);
        check("rst_mem_addr", mem_addr, '0);
        check("rst_mem_wdata", mem_wdata, '0);
        rst = 1'b0;
        @(negedge clk);

        // Write then read back through port 0
        serve(1'b0, 1'b1, 32'd5, 32'h0000_1234, '0);
        serve(1'b0, 1'b0, 32'd5, '0, 32'h0000_1234);
        check("wr_rd_rdata0_hold", rdata0, 32'h0000_1234);

        // Simultaneous requests right after reset: port 0 first
        rst = 1'b1;
        #1;
        check("rst2_rdata0", rdata0, '0);
        @(negedge clk);
        rst = 1'b0;
        e.port = 1'b0; e.chk_rdata = 1'b1; e.rdata = pat(3); e.err = 1'b0; sb.push_back(e);
        e.port = 1'b1; e.chk_rdata = 1'b1; e.rdata = pat(4); e.err = 1'b0; sb.push_back(e);
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'd3;
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'd4;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            check1("tie_ack0", ack0, k == 2);
            check1("tie_ack1", ack1, k == 5);
            if (k == 2) req0 = 1'b0;
            if (k == 5) req1 = 1'b0;
        end

        // Both held: grants alternate 0,1,0,1,0,1
        for (int k = 0; k < 6; k++) begin
            e.port      = k[0];
            e.chk_rdata = 1'b1;
            e.rdata     = k[0] ? pat(11) : pat(10);
            e.err       = 1'b0;
            sb.push_back(e);
        end
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'd10;
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'd11;
        n = 0;
        for (int k = 0; k < 30 && n < 6; k++) begin
            @(negedge clk);
            if (ack0 || ack1) n++;
        end
        req0 = 1'b0; req1 = 1'b0;
        check("alt_ack_count", 32'(n), 32'd6);
        @(negedge clk);
        @(negedge clk);
        check("alt_sb_empty", 32'(sb.size()), 32'd0);

        // Out-of-range write from port 1
        check("oor_rdata1_before", rdata1, pat(11));
        serve(1'b1, 1'b1, 32'd100, 32'hFFFF_0000, '0);
        nd = 0;
        for (int i = 0; i < DEPTH; i++)
            if (i != 5 && written[i]) nd++;
        check("oor_mem_unchanged", 32'(nd), 32'd0);

        // Reset during ACCESS of a write to addr 7
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'd7; wdata0 = 32'h0000_BEEF;
        @(posedge clk);
        #1;
        check1("rst_acc_strobe_before", mem_write, 1'b1);
        rst = 1'b1;
        req0 = 1'b0;
        #1;
        check1("rst_acc_write_off", mem_write, 1'b0);
        check1("rst_acc_ack", ack0 | ack1, 1'b0);
        check1("rst_acc_err", err, 1'b0);
        check("rst_acc_mem_addr", mem_addr, '0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check1("rst_acc_word7_untouched", written[7], 1'b0);
        serve(1'b0, 1'b0, 32'd7, '0, pat(7));
        check1("after_rst_word7_untouched", written[7], 1'b0);

        check("final_sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule
